// File: rtl/mandelbrot_pkg.sv
// ---------------------------------------------------------------------------
// mandelbrot_pkg
// Shared types and constants for the Mandelbrot scan controller slice.
//   fixed_t      : signed Q3.29 coordinate word
//   iter_t       : iteration count returned by the point engine
//   index_t      : 16-bit column/row index
//   scan_state_t : frame sequencing states of the scan controller
// ---------------------------------------------------------------------------
package mandelbrot_pkg;

    localparam int FIXED_POINT_FRACTIONAL_BITS = 29;
    localparam int MAX_ITERATION_BITS          = 9;
    localparam int INDEX_BITS                  = 16;

    typedef logic signed [31:0]             fixed_t;
    typedef logic [MAX_ITERATION_BITS:0]    iter_t;
    typedef logic [INDEX_BITS-1:0]          index_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        ADVANCE
    } scan_state_t;

endpackage

// File: rtl/mandelbrot_scan_controller_if.sv
// ---------------------------------------------------------------------------
// mandelbrot_scan_controller_if
// Groups the two handshaked buses of the scan controller:
//   point bus : pt_req/pt_ack/pt_busy/pt_done toward the iteration engine,
//               with pt_x/pt_y/pt_max_iterations and pt_iteration_count
//   pixel bus : pix_valid/pix_ready stream toward the framebuffer writer,
//               with pix_data/pix_col/pix_row/pix_last
// Modports:
//   master : the scan controller side
//   slave  : the engine + pixel consumer side
// ---------------------------------------------------------------------------
interface mandelbrot_scan_controller_if;
    import mandelbrot_pkg::*;

    logic        pt_req;
    logic        pt_ack;
    logic        pt_busy;
    logic        pt_done;
    iter_t       pt_iteration_count;
    fixed_t      pt_x;
    fixed_t      pt_y;
    logic [31:0] pt_max_iterations;

    logic        pix_valid;
    logic        pix_ready;
    iter_t       pix_data;
    index_t      pix_col;
    index_t      pix_row;
    logic        pix_last;

    modport master (
        output pt_req, pt_x, pt_y, pt_max_iterations,
        input  pt_ack, pt_busy, pt_done, pt_iteration_count,
        output pix_valid, pix_data, pix_col, pix_row, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pt_req, pt_x, pt_y, pt_max_iterations,
        output pt_ack, pt_busy, pt_done, pt_iteration_count,
        input  pix_valid, pix_data, pix_col, pix_row, pix_last,
        output pix_ready
    );

endinterface

// File: rtl/mandelbrot_coord_stepper.sv
// ---------------------------------------------------------------------------
// mandelbrot_coord_stepper
// Owns the raster position of the scan: col/row counters and the matching
// Q3.29 coordinate accumulators.
//   clk, reset (async, active-low)
//   load     : latch x_min/x_step/y_step, set pt_x=x_min, pt_y=y_max, col=row=0
//   advance  : step one pixel in raster order (wraps to next row at H_PIXELS-1)
//   x_min, y_max, x_step, y_step : frame geometry, sampled on load
//   pt_x, pt_y : current point coordinate
//   col, row   : current pixel index
//   last       : current pixel is the final one of the frame
// ---------------------------------------------------------------------------
module mandelbrot_coord_stepper
    import mandelbrot_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   advance,
    input  fixed_t x_min,
    input  fixed_t y_max,
    input  fixed_t x_step,
    input  fixed_t y_step,
    output fixed_t pt_x,
    output fixed_t pt_y,
    output index_t col,
    output index_t row,
    output logic   last
);

    localparam index_t LAST_COL = index_t'(H_PIXELS - 1);
    localparam index_t LAST_ROW = index_t'(V_PIXELS - 1);

    fixed_t x_min_q;
    fixed_t x_step_q;
    fixed_t y_step_q;

    // Rows are walked top-down, so the imaginary part decreases by y_step at
    // each line wrap; all arithmetic wraps in 32-bit two's complement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_min_q  <= '0;
            x_step_q <= '0;
            y_step_q <= '0;
            pt_x     <= '0;
            pt_y     <= '0;
            col      <= '0;
            row      <= '0;
        end else if (load) begin
            x_min_q  <= x_min;
            x_step_q <= x_step;
            y_step_q <= y_step;
            pt_x     <= x_min;
            pt_y     <= y_max;
            col      <= '0;
            row      <= '0;
        end else if (advance) begin
            if (col == LAST_COL) begin
                col  <= '0;
                row  <= row + index_t'(1);
                pt_x <= x_min_q;
                pt_y <= pt_y - y_step_q;
            end else begin
                col  <= col + index_t'(1);
                pt_x <= pt_x + x_step_q;
            end
        end
    end

    assign last = (col == LAST_COL) && (row == LAST_ROW);

endmodule

// File: rtl/mandelbrot_scan_controller.sv
// ---------------------------------------------------------------------------
// mandelbrot_scan_controller
// Frame-level initiator for the single-point Mandelbrot iteration engine.
// Walks an H_PIXELS x V_PIXELS grid in raster order, issues one point at a
// time to the engine and streams the returned iteration counts out as pixels.
// Ports:
//   clk, reset (async, active-low)
//   start          : one-cycle pulse, begins a frame when idle
//   abort          : level, ends the frame early
//   x_min, y_max   : Q3.29 top-left coordinate
//   x_step, y_step : Q3.29 per-column increment / per-row decrement
//   max_iterations : iteration limit forwarded to the engine
//   bus            : point + pixel handshakes (master modport)
//   busy           : frame in progress
//   frame_done     : one-cycle pulse at frame end (normal or aborted)
// Optional (macro MANDELBROT_SCAN_PERF_EN):
//   frame_cycles     : saturating clock count while busy
//   total_iterations : saturating sum of emitted pix_data
// ---------------------------------------------------------------------------
module mandelbrot_scan_controller
    import mandelbrot_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  fixed_t      x_min,
    input  fixed_t      y_max,
    input  fixed_t      x_step,
    input  fixed_t      y_step,
    input  logic [31:0] max_iterations,
    mandelbrot_scan_controller_if.master bus,
    output logic        busy,
    output logic        frame_done
`ifdef MANDELBROT_SCAN_PERF_EN
    ,
    output logic [31:0] frame_cycles,
    output logic [31:0] total_iterations
`endif
);

    scan_state_t state;
    logic        abort_pending;

    logic        step_load;
    logic        step_advance;
    fixed_t      step_x;
    fixed_t      step_y;
    index_t      step_col;
    index_t      step_row;
    logic        step_last;

    assign step_load    = (state == IDLE) && start;
    assign step_advance = (state == ADVANCE) && !step_last;

    mandelbrot_coord_stepper #(
        .H_PIXELS (H_PIXELS),
        .V_PIXELS (V_PIXELS)
    ) u_stepper (
        .clk     (clk),
        .reset   (reset),
        .load    (step_load),
        .advance (step_advance),
        .x_min   (x_min),
        .y_max   (y_max),
        .x_step  (x_step),
        .y_step  (y_step),
        .pt_x    (step_x),
        .pt_y    (step_y),
        .col     (step_col),
        .row     (step_row),
        .last    (step_last)
    );

    // The stepper only moves in ADVANCE, so the coordinates stay stable from
    // ISSUE entry until the engine reports done.
    assign bus.pt_x = step_x;
    assign bus.pt_y = step_y;

    // Frame sequencer. abort_pending remembers an abort seen while a point is
    // in flight or a pixel is pending, so a short abort pulse is still honoured
    // once the outstanding transaction has drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            abort_pending         <= 1'b0;
            busy                  <= 1'b0;
            frame_done            <= 1'b0;
            bus.pt_req            <= 1'b0;
            bus.pt_max_iterations <= '0;
            bus.pix_valid         <= 1'b0;
            bus.pix_data          <= '0;
            bus.pix_col           <= '0;
            bus.pix_row           <= '0;
            bus.pix_last          <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state                 <= ISSUE;
                        busy                  <= 1'b1;
                        abort_pending         <= 1'b0;
                        bus.pt_max_iterations <= max_iterations;
                    end
                end
                ISSUE: begin
                    if (bus.pt_req && bus.pt_ack) begin
                        bus.pt_req <= 1'b0;
                        state      <= WAIT;
                        if (abort) begin
                            abort_pending <= 1'b1;
                        end
                    end else if (abort) begin
                        bus.pt_req    <= 1'b0;
                        frame_done    <= 1'b1;
                        busy          <= 1'b0;
                        abort_pending <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        bus.pt_req <= !bus.pt_busy;
                    end
                end
                WAIT: begin
                    if (bus.pt_done) begin
                        if (abort || abort_pending) begin
                            frame_done    <= 1'b1;
                            busy          <= 1'b0;
                            abort_pending <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            bus.pix_data  <= bus.pt_iteration_count;
                            bus.pix_col   <= step_col;
                            bus.pix_row   <= step_row;
                            bus.pix_last  <= step_last;
                            bus.pix_valid <= 1'b1;
                            state         <= EMIT;
                        end
                    end else if (abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.pix_ready) begin
                        bus.pix_valid <= 1'b0;
                        bus.pix_last  <= 1'b0;
                        if (abort || abort_pending) begin
                            frame_done    <= 1'b1;
                            busy          <= 1'b0;
                            abort_pending <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            state <= ADVANCE;
                        end
                    end else if (abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                ADVANCE: begin
                    if (step_last) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MANDELBROT_SCAN_PERF_EN
    logic [32:0] iteration_sum;

    assign iteration_sum = {1'b0, total_iterations} + 33'(bus.pix_data);

    // Both counters restart on an accepted start and saturate at all-ones;
    // frame_cycles naturally holds once busy drops at frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cycles     <= '0;
            total_iterations <= '0;
        end else if (step_load) begin
            frame_cycles     <= '0;
            total_iterations <= '0;
        end else begin
            if (busy && (frame_cycles != '1)) begin
                frame_cycles <= frame_cycles + 32'd1;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                total_iterations <= iteration_sum[32] ? '1 : iteration_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mandelbrot_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_mandelbrot_scan_controller
// Directed bench: dut0 is a 3x2 scan driven by a fixed-latency engine model
// whose result encodes the pixel position; dut1 is a 1x1 scan driven by a
// behavioural Mandelbrot iteration model.
// ---------------------------------------------------------------------------
module tb_mandelbrot_scan_controller;

    logic        clk;
    logic        reset;
    logic        start0;
    logic        abort0;
    logic        start1;
    logic        abort1;
    logic [31:0] x_min;
    logic [31:0] y_max;
    logic [31:0] x_step;
    logic [31:0] y_step;
    logic [31:0] max_iter;
    logic        busy0;
    logic        busy1;
    logic        frame_done0;
    logic        frame_done1;

    int tests_run;
    int tests_failed;

    mandelbrot_scan_controller_if if0 ();
    mandelbrot_scan_controller_if if1 ();

`ifdef MANDELBROT_SCAN_PERF_EN
    logic [31:0] fc0, ti0, fc1, ti1;
`endif

    mandelbrot_scan_controller #(.H_PIXELS(3), .V_PIXELS(2)) dut0 (
        .clk            (clk),
        .reset          (reset),
        .start          (start0),
        .abort          (abort0),
        .x_min          (x_min),
        .y_max          (y_max),
        .x_step         (x_step),
        .y_step         (y_step),
        .max_iterations (max_iter),
        .bus            (if0),
        .busy           (busy0),
        .frame_done     (frame_done0)
`ifdef MANDELBROT_SCAN_PERF_EN
        ,
        .frame_cycles     (fc0),
        .total_iterations (ti0)
`endif
    );

    mandelbrot_scan_controller #(.H_PIXELS(1), .V_PIXELS(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .start          (start1),
        .abort          (abort1),
        .x_min          (x_min),
        .y_max          (y_max),
        .x_step         (x_step),
        .y_step         (y_step),
        .max_iterations (max_iter),
        .bus            (if1),
        .busy           (busy1),
        .frame_done     (frame_done1)
`ifdef MANDELBROT_SCAN_PERF_EN
        ,
        .frame_cycles     (fc1),
        .total_iterations (ti1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected coordinates per column / row of the 3x2 frame.
    logic [31:0] exp_x [3];
    logic [31:0] exp_y [2];

    // Engine0 and monitor logs.
    logic [31:0] x_log [$];
    logic [31:0] y_log [$];
    logic [9:0]  pd [$];
    logic [15:0] pc [$];
    logic [15:0] pr [$];
    logic        pl [$];
    int          ack_cnt;
    int          done_cnt;
    int          fd_cnt;
    int          done_at_fd;
    int          req_rise;
    logic        req_prev;

    // Result encodes position: col from x (x_min = -2.0, step 1.0), row from y.
    function automatic logic [9:0] position_count(logic [31:0] x, logic [31:0] y);
        logic [31:0] c;
        logic [31:0] r;
        c = (x + 32'h4000_0000) >> 29;
        r = (32'h2000_0000 - y) >> 29;
        return 10'(r * 3 + c);
    endfunction

    // Straightforward escape-time iteration in Q3.29.
    function automatic logic [9:0] mandel_count(logic [31:0] cx, logic [31:0] cy, logic [31:0] maxit);
        longint zr, zi, r2, i2, t, cxl, cyl;
        zr  = 0;
        zi  = 0;
        cxl = longint'($signed(cx));
        cyl = longint'($signed(cy));
        for (int i = 0; i < int'(maxit); i++) begin
            r2 = (zr * zr) >>> 29;
            i2 = (zi * zi) >>> 29;
            if (r2 + i2 > (longint'(4) <<< 29)) return 10'(i);
            t  = r2 - i2 + cxl;
            zi = ((2 * zr * zi) >>> 29) + cyl;
            zr = t;
        end
        return 10'(maxit);
    endfunction

    // Engine model for dut0: accepts a request, stays busy, completes after 5 negedges.
    initial begin
        int st;
        int cnt;
        logic [31:0] ex, ey;
        st = 0; cnt = 0; ex = '0; ey = '0;
        if0.pt_ack = 1'b0; if0.pt_busy = 1'b0; if0.pt_done = 1'b0; if0.pt_iteration_count = '0;
        forever begin
            @(negedge clk);
            if0.pt_ack  = 1'b0;
            if0.pt_done = 1'b0;
            if (!reset) begin
                st = 0;
                if0.pt_busy = 1'b0;
            end else if (st == 0) begin
                if (if0.pt_req) begin
                    if0.pt_ack  = 1'b1;
                    if0.pt_busy = 1'b1;
                    ex = if0.pt_x;
                    ey = if0.pt_y;
                    x_log.push_back(ex);
                    y_log.push_back(ey);
                    ack_cnt++;
                    cnt = 5;
                    st  = 1;
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    if0.pt_done = 1'b1;
                    if0.pt_busy = 1'b0;
                    if0.pt_iteration_count = position_count(ex, ey);
                    done_cnt++;
                    st = 0;
                end
            end
        end
    end

    // Engine model for dut1: same handshake, result from the iteration model.
    initial begin
        int st;
        int cnt;
        logic [31:0] ex, ey, em;
        st = 0; cnt = 0; ex = '0; ey = '0; em = '0;
        if1.pt_ack = 1'b0; if1.pt_busy = 1'b0; if1.pt_done = 1'b0; if1.pt_iteration_count = '0;
        forever begin
            @(negedge clk);
            if1.pt_ack  = 1'b0;
            if1.pt_done = 1'b0;
            if (!reset) begin
                st = 0;
                if1.pt_busy = 1'b0;
            end else if (st == 0) begin
                if (if1.pt_req) begin
                    if1.pt_ack  = 1'b1;
                    if1.pt_busy = 1'b1;
                    ex = if1.pt_x;
                    ey = if1.pt_y;
                    em = if1.pt_max_iterations;
                    cnt = 5;
                    st  = 1;
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    if1.pt_done = 1'b1;
                    if1.pt_busy = 1'b0;
                    if1.pt_iteration_count = mandel_count(ex, ey, em);
                    st = 0;
                end
            end
        end
    end

    // Pixel/frame monitor for dut0.
    initial begin
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (if0.pix_valid && if0.pix_ready) begin
                pd.push_back(if0.pix_data);
                pc.push_back(if0.pix_col);
                pr.push_back(if0.pix_row);
                pl.push_back(if0.pix_last);
            end
            if (frame_done0) begin
                fd_cnt++;
                done_at_fd = done_cnt;
            end
            if (if0.pt_req && !req_prev) req_rise++;
            req_prev = if0.pt_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        x_log.delete(); y_log.delete();
        pd.delete(); pc.delete(); pr.delete(); pl.delete();
        ack_cnt = 0; done_cnt = 0; fd_cnt = 0; done_at_fd = 0; req_rise = 0;
    endtask

    task automatic pulse_start0();
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_frame0(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fd_cnt != 0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (fd_cnt != 0) seen = 1'b1;
    endtask

    task automatic set_geometry();
        x_min    = 32'hC000_0000;
        x_step   = 32'h2000_0000;
        y_max    = 32'h2000_0000;
        y_step   = 32'h2000_0000;
        max_iter = 32'd255;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({if0.pt_req, if0.pix_valid, busy0, frame_done0, if0.pix_last} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b, required 00000",
                     {if0.pt_req, if0.pix_valid, busy0, frame_done0, if0.pix_last});
        end
        tests_run++;
        if ({if0.pt_x, if0.pt_y, if0.pix_data, if0.pix_col, if0.pix_row} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: x=%h y=%h d=%0d c=%0d r=%0d, required all 0",
                     if0.pt_x, if0.pt_y, if0.pix_data, if0.pix_col, if0.pix_row);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_raster();
        bit seen;
        clear_logs();
        set_geometry();
        pulse_start0();
        tests_run++;
        if (busy0 !== 1'b1 || if0.pt_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL launch: busy=%b pt_req=%b, required busy=1 pt_req=0", busy0, if0.pt_req);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (if0.pt_req !== 1'b1 || if0.pt_max_iterations !== 32'd255) begin
            tests_failed++;
            $display("[TB] FAIL start_latency: pt_req=%b max=%0d, required 1 and 255",
                     if0.pt_req, if0.pt_max_iterations);
        end
        wait_frame0(500, seen);
        tests_run++;
        if (!seen || pd.size() != 6 || busy0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL raster_frame: done=%b pixels=%0d busy=%b, required 1, 6, 0",
                     seen, pd.size(), busy0);
        end
        for (int i = 0; i < 6 && i < pd.size(); i++) begin
            tests_run++;
            if (pd[i] !== 10'(i) || pc[i] !== 16'(i % 3) || pr[i] !== 16'(i / 3) || pl[i] !== (i == 5)) begin
                tests_failed++;
                $display("[TB] FAIL raster_pix%0d: data=%0d col=%0d row=%0d last=%b, required %0d %0d %0d %b",
                         i, pd[i], pc[i], pr[i], pl[i], i, i % 3, i / 3, (i == 5));
            end
        end
        for (int i = 0; i < 6 && i < x_log.size(); i++) begin
            tests_run++;
            if (x_log[i] !== exp_x[i % 3] || y_log[i] !== exp_y[i / 3]) begin
                tests_failed++;
                $display("[TB] FAIL raster_coord%0d: x=%h y=%h, required x=%h y=%h",
                         i, x_log[i], y_log[i], exp_x[i % 3], exp_y[i / 3]);
            end
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (fd_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL raster_frame_done: pulses=%0d, required 1", fd_cnt);
        end
    endtask

    task automatic test_stall();
        bit seen;
        clear_logs();
        set_geometry();
        pulse_start0();
        for (int i = 0; i < 300 && pd.size() < 2; i++) @(negedge clk);
        tick();
        if0.pix_ready = 1'b0;
        for (int i = 0; i < 100 && !if0.pix_valid; i++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (if0.pix_valid !== 1'b1 || if0.pix_data !== 10'd2 || if0.pix_col !== 16'd2 ||
                if0.pix_row !== 16'd0 || if0.pt_req !== 1'b0 || pd.size() != 2) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: valid=%b data=%0d col=%0d row=%0d req=%b pixels=%0d, required 1 2 2 0 0 2",
                         c, if0.pix_valid, if0.pix_data, if0.pix_col, if0.pix_row, if0.pt_req, pd.size());
            end
            @(negedge clk);
        end
        tick();
        if0.pix_ready = 1'b1;
        wait_frame0(500, seen);
        tests_run++;
        if (!seen || pd.size() != 6) begin
            tests_failed++;
            $display("[TB] FAIL stall_frame: done=%b pixels=%0d, required 1 and 6", seen, pd.size());
        end
        for (int i = 0; i < pd.size(); i++) begin
            tests_run++;
            if (pd[i] !== 10'(i)) begin
                tests_failed++;
                $display("[TB] FAIL stall_pix%0d: data=%0d, required %0d", i, pd[i], i);
            end
        end
    endtask

    task automatic test_real_engine();
        logic [9:0] expected;
        x_min    = 32'h0;
        y_max    = 32'h0;
        x_step   = 32'h2000_0000;
        y_step   = 32'h2000_0000;
        max_iter = 32'd100;
        expected = mandel_count(32'h0, 32'h0, 32'd100);
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 200 && !if1.pix_valid; i++) @(negedge clk);
        tests_run++;
        if (if1.pix_valid !== 1'b1 || if1.pix_data !== expected || expected !== 10'd100 || if1.pix_last !== 1'b1 ||
            if1.pix_col !== 16'd0 || if1.pix_row !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL real_engine: valid=%b data=%0d last=%b col=%0d row=%0d, required 1 100 1 0 0",
                     if1.pix_valid, if1.pix_data, if1.pix_last, if1.pix_col, if1.pix_row);
        end
        for (int i = 0; i < 20 && !frame_done1; i++) @(negedge clk);
        tests_run++;
        if (frame_done1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL real_engine_done: frame_done=%b, required 1", frame_done1);
        end
        @(negedge clk);
        tests_run++;
        if (busy1 !== 1'b0 || frame_done1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL real_engine_idle: busy=%b frame_done=%b, required 0 0", busy1, frame_done1);
        end
    endtask

    task automatic test_abort();
        bit seen;
        clear_logs();
        set_geometry();
        pulse_start0();
        for (int i = 0; i < 300 && ack_cnt < 2; i++) @(negedge clk);
        tick();
        abort0 = 1'b1;
        wait_frame0(100, seen);
        tick();
        abort0 = 1'b0;
        tests_run++;
        if (!seen || pd.size() != 1 || done_at_fd != 2 || busy0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_wait: done=%b pixels=%0d engine_done_at_end=%0d busy=%b, required 1 1 2 0",
                     seen, pd.size(), done_at_fd, busy0);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (req_rise != 2 || fd_cnt != 1 || if0.pt_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_quiet: requests=%0d frame_done=%0d req=%b, required 2 1 0",
                     req_rise, fd_cnt, if0.pt_req);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        clear_logs();
        set_geometry();
        pulse_start0();
        for (int i = 0; i < 100 && ack_cnt < 1; i++) @(negedge clk);
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({if0.pt_req, if0.pix_valid, busy0, frame_done0, if0.pix_last} !== 5'b0 ||
            if0.pt_x !== 32'h0 || if0.pt_y !== 32'h0 || if0.pt_max_iterations !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: ctrl=%b x=%h y=%h max=%0d, required all 0",
                     {if0.pt_req, if0.pix_valid, busy0, frame_done0, if0.pix_last},
                     if0.pt_x, if0.pt_y, if0.pt_max_iterations);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_logs();
        pulse_start0();
        wait_frame0(500, seen);
        tests_run++;
        if (!seen || pd.size() != 6) begin
            tests_failed++;
            $display("[TB] FAIL reset_rerun: done=%b pixels=%0d, required 1 and 6", seen, pd.size());
        end
        for (int i = 0; i < pd.size(); i++) begin
            tests_run++;
            if (pd[i] !== 10'(i) || pl[i] !== (i == 5)) begin
                tests_failed++;
                $display("[TB] FAIL reset_rerun_pix%0d: data=%0d last=%b, required %0d %b", i, pd[i], pl[i], i, (i == 5));
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit seen;
        clear_logs();
        set_geometry();
        pulse_start0();
        for (int i = 0; i < 300 && pd.size() < 2; i++) @(negedge clk);
        x_min = 32'h0;
        y_max = 32'h0;
        pulse_start0();
        wait_frame0(500, seen);
        repeat (20) @(negedge clk);
        tests_run++;
        if (!seen || pd.size() != 6 || fd_cnt != 1 || req_rise != 6 || busy0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL start_busy_frame: done=%b pixels=%0d frame_done=%0d requests=%0d busy=%b, required 1 6 1 6 0",
                     seen, pd.size(), fd_cnt, req_rise, busy0);
        end
        for (int i = 0; i < 6 && i < x_log.size() && i < pd.size(); i++) begin
            tests_run++;
            if (pd[i] !== 10'(i) || x_log[i] !== exp_x[i % 3] || y_log[i] !== exp_y[i / 3]) begin
                tests_failed++;
                $display("[TB] FAIL start_busy_pix%0d: data=%0d x=%h y=%h, required %0d %h %h",
                         i, pd[i], x_log[i], y_log[i], i, exp_x[i % 3], exp_y[i / 3]);
            end
        end
        set_geometry();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_x[0] = 32'hC000_0000;
        exp_x[1] = 32'hE000_0000;
        exp_x[2] = 32'h0000_0000;
        exp_y[0] = 32'h2000_0000;
        exp_y[1] = 32'h0000_0000;
        reset  = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        if0.pix_ready = 1'b1;
        if1.pix_ready = 1'b1;
        set_geometry();
        clear_logs();

        test_reset();
        test_raster();
        test_stall();
        test_real_engine();
        test_abort();
        test_reset_mid_frame();
        test_start_while_busy();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
